// File: rtl/bcd_disp_pkg.sv
// rtl/bcd_disp_pkg.sv - shared types and constants for the BCD digit scanner
package bcd_disp_pkg;

    localparam logic [3:0] BCD_BLANK = 4'hF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHOW  = 2'd1,
        GUARD = 2'd2
    } scan_state_e;

    function automatic int show_len(input int scan_div, input int blank_cycles);
        return scan_div - blank_cycles;
    endfunction

endpackage

// File: rtl/bcd_lz_blank.sv
// rtl/bcd_lz_blank.sv - leading-zero blanking mask over a packed BCD value
module bcd_lz_blank
    import bcd_disp_pkg::*;
#(
    parameter int NUM_DIGITS = 4
) (
    input  logic [4*NUM_DIGITS-1:0] digits,
    output logic [NUM_DIGITS-1:0]   blank
);

    // Digit 0 is never blanked so an all-zero value still shows a single 0.
    always_comb begin
        logic seen;
        seen  = 1'b0;
        blank = '0;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            seen     = seen | (digits[i*4 +: 4] != 4'd0);
            blank[i] = ~seen;
        end
    end

endmodule

// File: rtl/bcd_digit_scanner.sv
// rtl/bcd_digit_scanner.sv - multiplexed BCD display scanner; optional BCD_SCAN_LEADING_ZERO_BLANK_EN
module bcd_digit_scanner
    import bcd_disp_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic [4*NUM_DIGITS-1:0]       digits_in,
    input  logic                          load,
    output logic [3:0]                    bcd,
    output logic [NUM_DIGITS-1:0]         an,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
    output logic                          frame_done
);

    localparam int IDX_W    = $clog2(NUM_DIGITS);
    localparam int CNT_W    = $clog2(SCAN_DIV);
    localparam int W        = 4 * NUM_DIGITS;
    localparam int SHOW_LEN = show_len(SCAN_DIV, BLANK_CYCLES);

    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SHOW_LEN - 1);
    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    scan_state_e              state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [NUM_DIGITS-1:0]    an_q, an_d;
    logic [3:0]               bcd_q, bcd_d;
    logic                     frame_done_q, frame_done_d;
    logic [W-1:0]             shadow_q, shadow_d;
    logic [W-1:0]             active_q, active_d;
    logic                     pending_q, pending_d;
    logic                     boundary;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        frame_done_d = 1'b0;
        boundary     = 1'b0;
        if (!en) begin
            state_d = IDLE;
            cnt_d   = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = SHOW;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
                SHOW: begin
                    if (cnt_q == SHOW_LAST) begin
                        state_d = GUARD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                GUARD: begin
                    if (cnt_q == GUARD_LAST) begin
                        state_d = SHOW;
                        cnt_d   = '0;
                        if (idx_q == IDX_LAST) begin
                            idx_d        = '0;
                            frame_done_d = 1'b1;
                            boundary     = 1'b1;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            endcase
        end
    end

    // A load landing exactly on the frame edge bypasses the shadow so it is never lost.
    always_comb begin
        shadow_d  = shadow_q;
        active_d  = active_q;
        pending_d = pending_q;
        if (boundary) begin
            if (load) begin
                active_d  = digits_in;
                pending_d = 1'b0;
            end else if (pending_q) begin
                active_d  = shadow_q;
                pending_d = 1'b0;
            end
        end else if (load) begin
            shadow_d  = digits_in;
            pending_d = 1'b1;
        end
    end

`ifdef BCD_SCAN_LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] lz_blank;

    bcd_lz_blank #(.NUM_DIGITS(NUM_DIGITS)) u_lz_blank (
        .digits (active_d),
        .blank  (lz_blank)
    );
`endif

    // Outputs are decoded from next-state values so they move on the same edge as the FSM.
    always_comb begin
        an_d  = '1;
        bcd_d = BCD_BLANK;
        if (state_d == SHOW) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (idx_d == IDX_W'(i)) begin
                    an_d[i] = 1'b0;
`ifdef BCD_SCAN_LEADING_ZERO_BLANK_EN
                    bcd_d   = lz_blank[i] ? BCD_BLANK : active_d[i*4 +: 4];
`else
                    bcd_d   = active_d[i*4 +: 4];
`endif
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            an_q         <= '1;
            bcd_q        <= BCD_BLANK;
            frame_done_q <= 1'b0;
            shadow_q     <= '0;
            active_q     <= '0;
            pending_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            an_q         <= an_d;
            bcd_q        <= bcd_d;
            frame_done_q <= frame_done_d;
            shadow_q     <= shadow_d;
            active_q     <= active_d;
            pending_q    <= pending_d;
        end
    end

    assign bcd        = bcd_q;
    assign an         = an_q;
    assign digit_idx  = idx_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_bcd_digit_scanner.sv
// tb/tb_bcd_digit_scanner.sv - directed self-checking bench for bcd_digit_scanner
module tb_bcd_digit_scanner;

    localparam int ND = 4;
    localparam int SD = 8;
    localparam int BC = 2;
    localparam int SL = SD - BC;
    localparam int FRAME = ND * SD;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        load;
    logic [15:0] digits_in;
    logic [3:0]  bcd;
    logic [3:0]  an;
    logic [1:0]  digit_idx;
    logic        frame_done;

    int n_vec = 0;
    int n_err = 0;
    int frame_no = 0;

    always #5 clk = ~clk;

    bcd_digit_scanner #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLANK_CYCLES(BC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .digits_in  (digits_in),
        .load       (load),
        .bcd        (bcd),
        .an         (an),
        .digit_idx  (digit_idx),
        .frame_done (frame_done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] exp_bcd(input logic [15:0] val, input int slot);
        logic [15:0] v;
        v = val;
`ifdef BCD_SCAN_LEADING_ZERO_BLANK_EN
        if (slot > 0 && (v >> (4 * slot)) == 16'd0) return 4'hF;
`endif
        return v[4*slot +: 4];
    endfunction

    task automatic check_dark(input string tag);
        chk({tag, " an"}, 32'(an), 32'hF);
        chk({tag, " bcd"}, 32'(bcd), 32'hF);
        chk({tag, " idx"}, 32'(digit_idx), 32'h0);
        chk({tag, " frame_done"}, 32'(frame_done), 32'h0);
    endtask

    task automatic wait_frame();
        int found;
        found = 0;
        for (int k = 0; k < 3 * FRAME; k++) begin
            @(negedge clk);
            if (frame_done === 1'b1) begin
                found = 1;
                break;
            end
        end
        chk("frame_wait", 32'(found), 32'h1);
    endtask

    // Entered on the sample where frame_done is high; leaves on the next frame's first sample.
    task automatic check_frame(input logic [15:0] val,
                               input int a_at, input logic [15:0] a_val,
                               input int b_at, input logic [15:0] b_val);
        int slot;
        int pos;
        logic [3:0] exp_an;
        logic [3:0] exp_b;
        frame_no++;
        for (int c = 0; c < FRAME; c++) begin
            slot   = c / SD;
            pos    = c % SD;
            exp_an = 4'hF;
            exp_b  = 4'hF;
            if (pos < SL) begin
                exp_an[slot] = 1'b0;
                exp_b        = exp_bcd(val, slot);
            end
            chk($sformatf("f%0d c%0d an", frame_no, c), 32'(an), 32'(exp_an));
            chk($sformatf("f%0d c%0d bcd", frame_no, c), 32'(bcd), 32'(exp_b));
            chk($sformatf("f%0d c%0d idx", frame_no, c), 32'(digit_idx), 32'(slot));
            chk($sformatf("f%0d c%0d frame_done", frame_no, c), 32'(frame_done), 32'(c == 0));
            if (c == a_at) begin
                digits_in = a_val;
                load      = 1'b1;
            end else if (c == b_at) begin
                digits_in = b_val;
                load      = 1'b1;
            end else begin
                load = 1'b0;
            end
            @(negedge clk);
        end
        load = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        en        = 1'b0;
        load      = 1'b0;
        digits_in = 16'h0;
        repeat (3) @(negedge clk);
        check_dark("reset");
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_dark($sformatf("idle%0d", i));
        end

        digits_in = 16'h1234;
        load      = 1'b1;
        @(negedge clk);
        load = 1'b0;
        en   = 1'b1;
        wait_frame();
        check_frame(16'h1234, -1, 16'h0, -1, 16'h0);
        check_frame(16'h1234, 10, 16'h5678, -1, 16'h0);
        check_frame(16'h5678, 3, 16'h5678, FRAME - 1, 16'h9999);
        check_frame(16'h9999, -1, 16'h0, -1, 16'h0);
        check_frame(16'h9999, -1, 16'h0, -1, 16'h0);

        repeat (2 * SD + 1) @(negedge clk);
        chk("pre_drop an", 32'(an), 32'hB);
        chk("pre_drop idx", 32'(digit_idx), 32'h2);
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_dark($sformatf("drop%0d", i));
        end
        en = 1'b1;
        @(negedge clk);
        chk("resume an", 32'(an), 32'hE);
        chk("resume bcd", 32'(bcd), 32'h9);
        chk("resume frame_done", 32'(frame_done), 32'h0);

        repeat (SD + SL) @(negedge clk);
        chk("guard an", 32'(an), 32'hF);
        chk("guard idx", 32'(digit_idx), 32'h1);
        #2 rst_n = 1'b0;
        #1 check_dark("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        wait_frame();
        check_frame(16'h0000, 5, 16'h0042, -1, 16'h0);
        check_frame(16'h0042, 5, 16'h0000, -1, 16'h0);
        check_frame(16'h0000, -1, 16'h0, -1, 16'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bcd_digit_scanner.md
Name: bcd_digit_scanner

Overview:
- Time-multiplexes NUM_DIGITS packed BCD digits onto one 4-bit BCD bus that feeds the segment7 decoder. Drives active-low digit enables (an) for a common-anode multi-digit display.
- Double-buffers the display value so that a new value only takes effect at a frame boundary (no tearing).
- Inserts an all-off guard interval between digits to suppress ghosting.

Parameters:
- NUM_DIGITS, 4, number of display digits (2..8)
- SCAN_DIV, 50000, clock cycles per digit slot, guard included; must be > BLANK_CYCLES
- BLANK_CYCLES, 16, guard cycles per slot with all anodes off; >= 1

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- en  in  1  scan enable; low = display dark
- digits_in  in  4*NUM_DIGITS  packed BCD value; digit 0 (least significant) at [3:0]
- load  in  1  one-cycle strobe; captures digits_in into the shadow buffer
- bcd  out  4  BCD code to the decoder; 4'hF = blank (decoder outputs all segments off)
- an  out  NUM_DIGITS  active-low digit enables; at most one bit is low at a time
- digit_idx  out  $clog2(NUM_DIGITS)  index of the digit currently addressed
- frame_done  out  1  one-cycle pulse when the last digit's slot ends

Behaviour:
- Clock and reset: single clock clk. Reset rst_n is asynchronous, active-low.
- Reset values: state=IDLE, an=all 1s, bcd=4'hF, digit_idx=0, frame_done=0, cnt=0, shadow=0, active=0, pending=0.
- Outputs are registered. an, bcd and digit_idx change on the same edge as the state.
- State IDLE: an all 1s, bcd=4'hF. If en=1, the next edge goes to SHOW with digit_idx=0 and cnt=0.
- State SHOW:
  - an[digit_idx]=0 and bcd=active[digit_idx].
  - Lasts SHOW_LEN = SCAN_DIV-BLANK_CYCLES cycles (cnt counts 0..SHOW_LEN-1).
  - After that, go to GUARD with cnt=0.
- State GUARD:
  - an all 1s, bcd=4'hF, for BLANK_CYCLES cycles.
  - At the end, go to SHOW with digit_idx+1 and cnt=0.
  - If digit_idx was NUM_DIGITS-1, wrap digit_idx to 0, assert frame_done for one cycle (same edge as the return to SHOW), and perform the buffer swap.
- Buffer swap:
  - At the frame-boundary edge, if pending=1: active<=shadow, pending<=0.
  - If load=1 on that same edge: active<=digits_in directly (bypass) and pending stays 0.
- load outside a frame boundary: shadow<=digits_in, pending<=1. A later load overwrites the shadow (last value wins).
- en deasserted in any state: the next edge goes to IDLE with cnt=0, digit_idx=0 and outputs blanked. shadow, active and pending are retained.
- Codes 10..15 in the digit data pass through unchanged; the decoder blanks them.
- Timing: a slot is exactly SCAN_DIV cycles and a frame is exactly NUM_DIGITS*SCAN_DIV cycles.
- Latency: a load completes in at most one frame plus one cycle before it appears on bcd.
- Reset mid-operation: all registers return to their reset values immediately (asynchronous).
- cnt width is $clog2(SCAN_DIV). Comparisons use SHOW_LEN-1 and BLANK_CYCLES-1; no overflow is permitted.

Optional Feature:
- Macro: BCD_SCAN_LEADING_ZERO_BLANK_EN
- Defined: during SHOW, any digit position above the most significant non-zero digit of active drives bcd=4'hF; its anode still strobes normally. Digit 0 is never blanked, so a value of 0 shows a single "0". Significance is evaluated on the active buffer.
- Undefined: all digits are shown as stored and the extra logic is absent.

Decomposition:
- Package bcd_disp_pkg:
  - BCD_BLANK = 4'hF
  - state enum {IDLE, SHOW, GUARD} as a 2-bit typedef
  - localparam helper for SHOW_LEN
- One sub-module, bcd_lz_blank: combinational leading-zero mask over the active buffer. Instantiated only when BCD_SCAN_LEADING_ZERO_BLANK_EN is defined.
- The counter and FSM stay in the top module.

Test Plan (NUM_DIGITS=4, SCAN_DIV=8, BLANK_CYCLES=2; SHOW_LEN=6, frame=32 cycles):
- Reset/idle: hold rst_n=0, then release with en=0 -> an=4'b1111, bcd=4'hF, frame_done=0 indefinitely.
- Basic scan: load digits_in=16'h1234, then en=1 -> after the first frame boundary, per slot:
  - bcd=4 with an=1110 for 6 cycles, then an=1111 for 2 cycles
  - then 3/1101, 2/1011, 1/0111
  - frame_done pulses every 32 cycles
- Tear-free update: load 16'h5678 mid-frame -> the current frame completes showing 1234; the next frame shows 5678; pending clears on the swap edge.
- Simultaneous load at the frame-boundary edge with 16'h9999 while 16'h5678 is pending -> the next frame shows 9999.
- Mid-scan control: drop en during digit 2's SHOW -> next edge an=1111, bcd=F, digit_idx=0. Assert rst_n=0 asynchronously mid-GUARD -> outputs reset with no clock edge.
- Optional feature (macro defined): load 16'h0042 -> slots 3 and 2 give bcd=F with their anodes low; slots 1 and 0 give 4 and 2. Load 16'h0000 -> only digit 0 shows 0.
